add_subt_responder: RTL and testbench

ADD_SUBT_RESPONDER -- requirements
Module: add_subt_responder

---
 rtl/add_subt_responder.sv | 215 +++++++++++++++++++++
 tb/tb_add_subt_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_subt_responder.sv
// Fixed-latency IEEE-754 single-precision add/subtract responder for a CORDIC controller.
// Optional IEEE inf/NaN handling is enabled by defining ADD_SUBT_SPECIALS_EN.
module add_subt_responder (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Begin_SUM,
  input  logic        ADD_SUBT,
  input  logic [31:0] Data_X,
  input  logic [31:0] Data_Y,
  output logic        ACK_ADD_SUBT,
  output logic [31:0] Data_Result,
  output logic        overflow_flag,
  output logic        underflow_flag
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StAlign, StAdd, StNorm, StRound, StDone
  } state_e;

  state_e             state_q;
  logic               begin_q;
  logic               arm_q;
  logic [31:0]        x_q, y_q;
  logic               op_q;
  logic               sign_q;
  logic               eff_sub_q;
  logic signed [9:0]  exp_q;
  logic [7:0]         exp_diff_q;
  logic [23:0]        sig_a_q, sig_b_q;
  logic [26:0]        opb_q;
  logic [27:0]        sum_q;
  logic [26:0]        norm_q;
  logic               zero_q;
  logic               special_q;
  logic [31:0]        special_res_q;

  logic start;
  // arm_q blocks a Begin_SUM that was already high when reset was released.
  assign start = Begin_SUM & ~begin_q & arm_q;

  // Load stage: flush subnormals, apply the operation to Y's sign and order by magnitude.
  logic [30:0] mag_x, mag_y, big_mag, small_mag;
  logic        sy_eff, swap;
  always_comb begin
    mag_x     = (x_q[30:23] == 8'd0) ? 31'd0 : x_q[30:0];
    mag_y     = (y_q[30:23] == 8'd0) ? 31'd0 : y_q[30:0];
    sy_eff    = y_q[31] ^ op_q;
    swap      = mag_y > mag_x;
    big_mag   = swap ? mag_y : mag_x;
    small_mag = swap ? mag_x : mag_y;
  end

  logic        special_d;
  logic [31:0] special_res_d;
`ifdef ADD_SUBT_SPECIALS_EN
  logic x_inf, y_inf, x_nan, y_nan;
  always_comb begin
    x_inf     = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
    y_inf     = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
    x_nan     = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
    y_nan     = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
    special_d = (x_q[30:23] == 8'hFF) || (y_q[30:23] == 8'hFF);
    if (x_nan || y_nan || (x_inf && y_inf && (x_q[31] != sy_eff))) begin
      special_res_d = 32'h7FC00000;
    end else if (x_inf) begin
      special_res_d = {x_q[31], 8'hFF, 23'd0};
    end else begin
      special_res_d = {sy_eff, 8'hFF, 23'd0};
    end
  end
`else
  always_comb begin
    special_d     = 1'b0;
    special_res_d = 32'd0;
  end
`endif

  // Align stage: {significand, guard, round, sticky}.
  logic [49:0] shift_ext;
  logic [26:0] aligned_b;
  always_comb begin
    shift_ext = {sig_b_q, 26'd0} >> exp_diff_q;
    if (exp_diff_q >= 8'd26) begin
      aligned_b = {26'd0, |sig_b_q};
    end else begin
      aligned_b = {shift_ext[49:24], |shift_ext[23:0]};
    end
  end

  // Normalize stage: leading-zero count of the 27-bit sum.
  logic [4:0] lzc;
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i <= 26; i++) begin
      if (sum_q[i]) lzc = 5'(26 - i);
    end
  end

  // Round stage: nearest-even, then range checks.
  logic              round_up;
  logic [24:0]       rnd;
  logic [22:0]       mant_out;
  logic signed [9:0] exp_out;
  logic [31:0]       res_d;
  logic              ovf_d, unf_d;
  always_comb begin
    round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    rnd      = {1'b0, norm_q[26:3]} + {24'd0, round_up};
    if (rnd[24]) begin
      mant_out = rnd[23:1];
      exp_out  = exp_q + 10'sd1;
    end else begin
      mant_out = rnd[22:0];
      exp_out  = exp_q;
    end
    res_d = {sign_q, exp_out[7:0], mant_out};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (zero_q) begin
      res_d = 32'd0;
    end else if (exp_out <= 10'sd0) begin
      res_d = {sign_q, 31'd0};
      unf_d = 1'b1;
    end else if (exp_out >= 10'sd255) begin
      res_d = {sign_q, 8'hFF, 23'd0};
      ovf_d = 1'b1;
    end
    if (special_q) begin
      res_d = special_res_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StIdle;
      begin_q        <= 1'b0;
      arm_q          <= ~Begin_SUM;
      ACK_ADD_SUBT   <= 1'b0;
      Data_Result    <= 32'd0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
      x_q            <= 32'd0;
      y_q            <= 32'd0;
      op_q           <= 1'b0;
      sign_q         <= 1'b0;
      eff_sub_q      <= 1'b0;
      exp_q          <= 10'sd0;
      exp_diff_q     <= 8'd0;
      sig_a_q        <= 24'd0;
      sig_b_q        <= 24'd0;
      opb_q          <= 27'd0;
      sum_q          <= 28'd0;
      norm_q         <= 27'd0;
      zero_q         <= 1'b0;
      special_q      <= 1'b0;
      special_res_q  <= 32'd0;
    end else begin
      begin_q <= Begin_SUM;
      if (!Begin_SUM) arm_q <= 1'b1;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            x_q          <= Data_X;
            y_q          <= Data_Y;
            op_q         <= ADD_SUBT;
            ACK_ADD_SUBT <= 1'b0;
            state_q      <= StLoad;
          end
        end
        StLoad: begin
          sign_q        <= swap ? sy_eff : x_q[31];
          eff_sub_q     <= x_q[31] ^ sy_eff;
          exp_q         <= $signed({2'b00, big_mag[30:23]});
          exp_diff_q    <= big_mag[30:23] - small_mag[30:23];
          sig_a_q       <= (big_mag[30:23] == 8'd0) ? 24'd0 : {1'b1, big_mag[22:0]};
          sig_b_q       <= (small_mag[30:23] == 8'd0) ? 24'd0 : {1'b1, small_mag[22:0]};
          special_q     <= special_d;
          special_res_q <= special_res_d;
          state_q       <= StAlign;
        end
        StAlign: begin
          opb_q   <= aligned_b;
          state_q <= StAdd;
        end
        StAdd: begin
          if (eff_sub_q) sum_q <= {1'b0, sig_a_q, 3'd0} - {1'b0, opb_q};
          else           sum_q <= {1'b0, sig_a_q, 3'd0} + {1'b0, opb_q};
          state_q <= StNorm;
        end
        StNorm: begin
          zero_q <= (sum_q == 28'd0);
          if (sum_q[27]) begin
            norm_q <= {sum_q[27:2], sum_q[1] | sum_q[0]};
            exp_q  <= exp_q + 10'sd1;
          end else begin
            norm_q <= sum_q[26:0] << lzc;
            exp_q  <= exp_q - $signed({5'd0, lzc});
          end
          state_q <= StRound;
        end
        StRound: begin
          Data_Result    <= res_d;
          overflow_flag  <= ovf_d;
          underflow_flag <= unf_d;
          ACK_ADD_SUBT   <= 1'b1;
          state_q        <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_add_subt_responder.sv
// Self-checking bench for add_subt_responder: directed vectors, control corner cases and
// random operands against an exact-arithmetic reference model.
module tb_add_subt_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Begin_SUM = 1'b0;
  logic        ADD_SUBT = 1'b0;
  logic [31:0] Data_X = 32'd0;
  logic [31:0] Data_Y = 32'd0;
  logic        ACK_ADD_SUBT;
  logic [31:0] Data_Result;
  logic        overflow_flag;
  logic        underflow_flag;

  int tests = 0;
  int fails = 0;

  add_subt_responder dut (
    .CLK           (CLK),
    .RST           (RST),
    .Begin_SUM     (Begin_SUM),
    .ADD_SUBT      (ADD_SUBT),
    .Data_X        (Data_X),
    .Data_Y        (Data_Y),
    .ACK_ADD_SUBT  (ACK_ADD_SUBT),
    .Data_Result   (Data_Result),
    .overflow_flag (overflow_flag),
    .underflow_flag(underflow_flag)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sub;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Exact sum of the two operands scaled by 2^150, then a single round-to-nearest-even.
  function automatic void ref_model(input logic [31:0] x, input logic [31:0] y,
                                    input logic sub, output logic [31:0] r,
                                    output logic ovf, output logic unf);
    logic [299:0] ax, ay, mag, sig, rem, half, one;
    logic         sx, sy, s;
    int           p, k, e;
    sx  = x[31];
    sy  = y[31] ^ sub;
    ovf = 1'b0;
    unf = 1'b0;
    r   = 32'd0;
`ifdef ADD_SUBT_SPECIALS_EN
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
      if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0) ||
          (x[30:23] == 8'hFF && y[30:23] == 8'hFF && sx != sy)) r = 32'h7FC00000;
      else if (x[30:23] == 8'hFF) r = {sx, 8'hFF, 23'd0};
      else r = {sy, 8'hFF, 23'd0};
      return;
    end
`endif
    ax = '0;
    ay = '0;
    if (x[30:23] != 8'd0) ax = 300'({1'b1, x[22:0]}) << x[30:23];
    if (y[30:23] != 8'd0) ay = 300'({1'b1, y[22:0]}) << y[30:23];
    if (sx == sy) begin
      mag = ax + ay; s = sx;
    end else if (ax >= ay) begin
      mag = ax - ay; s = sx;
    end else begin
      mag = ay - ax; s = sy;
    end
    if (mag == '0) return;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    one = '0;
    one[0] = 1'b1;
    if (p <= 23) begin
      sig = mag << (23 - p);
    end else begin
      k    = p - 23;
      sig  = mag >> k;
      rem  = mag & ((one << k) - one);
      half = one << (k - 1);
      if (rem > half || (rem == half && sig[0])) sig = sig + one;
      if (sig[24]) begin
        sig = sig >> 1;
        p++;
      end
    end
    e = p - 23;
    if (e <= 0) begin
      r = {s, 31'd0}; unf = 1'b1;
    end else if (e >= 255) begin
      r = {s, 8'hFF, 23'd0}; ovf = 1'b1;
    end else begin
      r = {s, e[7:0], sig[22:0]};
    end
  endfunction

  // Edge on Begin_SUM, then require ACK exactly on the sixth rising edge.
  task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y,
                        input logic sub, input logic [31:0] er, input logic eo,
                        input logic eu);
    logic lat_ok;
    @(posedge CLK); #1;
    Data_X = x; Data_Y = y; ADD_SUBT = sub; Begin_SUM = 1'b1;
    lat_ok = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge CLK); #1;
      if (i < 6 && ACK_ADD_SUBT) lat_ok = 1'b0;
      if (i == 6 && !ACK_ADD_SUBT) lat_ok = 1'b0;
      if (i == 1) begin
        Begin_SUM = 1'b0;
        Data_X = $urandom; Data_Y = $urandom; ADD_SUBT = ~sub;
      end
    end
    chk({nm, " latency"}, 64'(lat_ok), 64'd1);
    chk({nm, " result"}, 64'(Data_Result), 64'(er));
    chk({nm, " flags"}, 64'({overflow_flag, underflow_flag}), 64'({eo, eu}));
  endtask

  vec_t        vecs [$];
  logic [31:0] rx, ry, er, r0;
  logic        rs, eo, eu, prev, ack_seen, stable;
  int          rises;

  initial begin
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0});
    vecs.push_back('{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000, 1'b0, 1'b0});
    vecs.push_back('{32'h40400000, 32'hC0000000, 1'b0, 32'h3F800000, 1'b0, 1'b0});
    vecs.push_back('{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 1'b0, 1'b0});
    vecs.push_back('{32'h4B7FFFFF, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b0});
`ifdef ADD_SUBT_SPECIALS_EN
    vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0});
    vecs.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0});
    vecs.push_back('{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 1'b0, 1'b0});
`endif

    repeat (3) @(posedge CLK);
    #1;
    chk("reset outputs", 64'({ACK_ADD_SUBT, overflow_flag, underflow_flag, Data_Result}),
        64'd0);
    RST = 1'b0;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].sub,
             vecs[i].res, vecs[i].ovf, vecs[i].unf);
    end

    // Begin_SUM held high for 20 cycles starting from DONE: one operation only.
    ref_model(32'h40A00000, 32'h3F000000, 1'b0, er, eo, eu);
    @(posedge CLK); #1;
    Data_X = 32'h40A00000; Data_Y = 32'h3F000000; ADD_SUBT = 1'b0; Begin_SUM = 1'b1;
    prev  = ACK_ADD_SUBT;
    rises = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      if (ACK_ADD_SUBT && !prev) rises++;
      prev = ACK_ADD_SUBT;
      if (i == 19) Begin_SUM = 1'b0;
    end
    chk("held start ack count", 64'(rises), 64'd1);
    chk("held start result", 64'(Data_Result), 64'(er));

    // Second edge while in ALIGN is dropped; first operation's result stands.
    ref_model(32'h41200000, 32'h40400000, 1'b1, er, eo, eu);
    @(posedge CLK); #1;
    Data_X = 32'h41200000; Data_Y = 32'h40400000; ADD_SUBT = 1'b1; Begin_SUM = 1'b1;
    @(posedge CLK); #1;
    Begin_SUM = 1'b0; Data_X = 32'h3F800000; Data_Y = 32'h3F800000; ADD_SUBT = 1'b0;
    @(posedge CLK); #1;
    Begin_SUM = 1'b1;
    @(posedge CLK); #1;
    Begin_SUM = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("align edge early ack", 64'(ACK_ADD_SUBT), 64'd0);
    @(posedge CLK); #1;
    chk("align edge ack", 64'(ACK_ADD_SUBT), 64'd1);
    chk("align edge result", 64'(Data_Result), 64'(er));
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (!ACK_ADD_SUBT || Data_Result !== er) stable = 1'b0;
    end
    chk("align edge done hold", 64'(stable), 64'd1);

    // Reset during ADD aborts the operation; held Begin_SUM must not restart it.
    @(posedge CLK); #1;
    Data_X = 32'h3F800000; Data_Y = 32'h40000000; ADD_SUBT = 1'b0; Begin_SUM = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("mid reset outputs",
        64'({ACK_ADD_SUBT, overflow_flag, underflow_flag, Data_Result}), 64'd0);
    RST = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (ACK_ADD_SUBT) ack_seen = 1'b1;
    end
    chk("no start after reset", 64'(ack_seen), 64'd0);
    Begin_SUM = 1'b0;
    run_op("post reset", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);

    // Random operands biased toward cancellation, near-equal exponents and range limits.
    for (int n = 0; n < 300; n++) begin
      rx = $urandom;
      ry = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: ry[30:23] = rx[30:23];
        1: ry[30:23] = rx[30:23] - 8'($urandom_range(0, 30));
        2: ;
        3: begin
          rx[30:23] = 8'($urandom_range(0, 3));
          ry[30:23] = 8'($urandom_range(0, 3));
        end
        default: begin
          rx[30:23] = 8'hFE;
          ry[30:23] = 8'hFE - 8'($urandom_range(0, 3));
        end
      endcase
      ref_model(rx, ry, rs, er, eo, eu);
      run_op($sformatf("rand%0d x=%h y=%h sub=%0d", n, rx, ry, rs), rx, ry, rs, er, eo, eu);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
